// File: rtl/lsu_ram_ctrl.sv
// rtl/lsu_ram_ctrl.sv - RV32I load/store adapter onto a word-wide dual-port data RAM
//
// Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests from the MEM stage into RAM port
// activity. Aligned SW writes straight through with no stall. SB/SH use a
// read-modify-write: the word is read in the accept cycle and merged/written
// back in RMW_MERGE. Loads read in the accept cycle and the extended result is
// registered in LOAD_WAIT, so it appears two cycles after accept.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req_*             MEM-stage request (valid/we/funct3/addr/wdata), req_ready handshake
//   rsp_valid/rdata   load response (1-cycle pulse, data held until next response)
//   err_o             1-cycle pulse after accepting a misaligned/illegal request
//   ram_w_*           RAM write port (enable, word address, data)
//   ram_r_*           RAM read port (enable, word address, data one cycle later)

module lsu_ram_ctrl #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          err_o,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [AW-1:0]   r_widx;
    logic [15:0]     r_wdata;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_err;

    logic [AW-1:0]   w_widx;
    logic            w_legal;
    logic            w_misaligned;
    logic            w_bad;
    logic            w_accept;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [DW-1:0]   w_load;
    logic [DW-1:0]   w_merged;

    // Address bits above the RAM word index are intentionally ignored.
    logic            w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[31:AW+2]};

    assign w_widx = req_addr[AW+1:2];

    // Loads: 000,001,010,100,101. Stores: 000,001,010 only.
    assign w_legal = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                            : ((req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]));

    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign w_bad    = !w_legal || w_misaligned;
    assign w_accept = req_valid && req_ready;

    // Load extraction from the word returned by the RAM in LOAD_WAIT.
    assign w_byte = ram_r_data[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? ram_r_data[31:16] : ram_r_data[15:0];

    always_comb begin
        w_load = ram_r_data;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = ram_r_data;
        endcase
    end

    // Sub-word store merge: funct3[0] distinguishes SH from SB.
    always_comb begin
        w_merged = ram_r_data;
        if (r_funct3[0]) begin
            if (r_off[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end else begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Next state and RAM port drive. Everything is forced low while rst is
    // asserted so nothing reaches the RAM from a dropped operation.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        ram_w_en   = 1'b0;
        ram_w_addr = '0;
        ram_w_data = '0;
        ram_r_en   = 1'b0;
        ram_r_addr = '0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid && !w_bad) begin
                        if (!req_we) begin
                            ram_r_en   = 1'b1;
                            ram_r_addr = w_widx;
                            w_next     = LOAD_WAIT;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            ram_w_en   = 1'b1;
                            ram_w_addr = w_widx;
                            ram_w_data = req_wdata;
                        end else begin
                            ram_r_en   = 1'b1;
                            ram_r_addr = w_widx;
                            w_next     = RMW_MERGE;
                        end
                    end
                end
                LOAD_WAIT: begin
                    w_next = IDLE;
                end
                RMW_MERGE: begin
                    ram_w_en   = 1'b1;
                    ram_w_addr = r_widx;
                    ram_w_data = w_merged;
                    w_next     = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_funct3    <= '0;
            r_off       <= '0;
            r_widx      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_err       <= w_accept && w_bad;
            r_rsp_valid <= (r_state == LOAD_WAIT);
            if (r_state == LOAD_WAIT) begin
                r_rsp_rdata <= w_load;
            end
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                r_widx   <= w_widx;
                r_wdata  <= req_wdata[15:0];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign err_o     = r_err;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// tb/tb_lsu_ram_ctrl.sv - self-checking bench for lsu_ram_ctrl against a byte-level memory model

module tb_lsu_ram_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;
    localparam int NB    = 1 << (AW + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          err_o;
    logic          ram_w_en;
    logic [AW-1:0] ram_w_addr;
    logic [31:0]   ram_w_data;
    logic          ram_r_en;
    logic [AW-1:0] ram_r_addr;
    logic [31:0]   ram_r_data;

    lsu_ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .err_o      (err_o),
        .ram_w_en   (ram_w_en),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_r_en   (ram_r_en),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data)
    );

    always #5 clk = ~clk;

    // Environment RAM: separate write port, 1-cycle registered read.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_w_en) ram[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= ram[ram_r_addr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, cyc, act, exp);
    endtask

    // Golden byte-addressed memory and per-cycle expectation tables.
    logic [7:0]    gmem [0:NB-1];
    bit            exp_w_en  [DEPTH];
    logic [AW-1:0] exp_w_addr[DEPTH];
    logic [31:0]   exp_w_data[DEPTH];
    bit            exp_r_en  [DEPTH];
    logic [AW-1:0] exp_r_addr[DEPTH];
    bit            exp_busy  [DEPTH];
    bit            exp_rsp   [DEPTH];
    logic [31:0]   exp_rdata [DEPTH];
    bit            exp_err   [DEPTH];

    bit          pend_valid;
    logic [13:0] pend_addr;
    int          pend_n;
    logic [31:0] pend_data;

    function automatic logic [31:0] gword(input logic [13:0] base);
        return {gmem[base+3], gmem[base+2], gmem[base+1], gmem[base]};
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr);
        logic [13:0] a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr[13:0];
        b = gmem[a];
        h = {gmem[a+1], gmem[a]};
        case (f3)
            3'b000:  return b[7]  ? (32'hFFFFFF00 | {24'd0, b}) : {24'd0, b};
            3'b100:  return {24'd0, b};
            3'b001:  return h[15] ? (32'hFFFF0000 | {16'd0, h}) : {16'd0, h};
            3'b101:  return {16'd0, h};
            default: return gword({a[13:2], 2'b00});
        endcase
    endfunction

    task automatic commit_pending();
        if (pend_valid) begin
            for (int i = 0; i < pend_n; i++) gmem[pend_addr + 14'(i)] = pend_data[8*i +: 8];
            pend_valid = 0;
        end
    endtask

    task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input int c);
        int          n;
        bit          legal;
        logic [13:0] base;
        logic [7:0]  by [4];
        commit_pending();
        n     = 1 << f3[1:0];
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        base  = {addr[13:2], 2'b00};
        if (!legal || (addr % n) != 0) begin
            exp_err[c+1] = 1;
        end else if (!we) begin
            exp_r_en[c]   = 1;
            exp_r_addr[c] = addr[13:2];
            exp_busy[c+1] = 1;
            exp_rsp[c+2]  = 1;
            exp_rdata[c+2] = load_val(f3, addr);
        end else if (n == 4) begin
            for (int i = 0; i < 4; i++) gmem[base + 14'(i)] = wd[8*i +: 8];
            exp_w_en[c]   = 1;
            exp_w_addr[c] = addr[13:2];
            exp_w_data[c] = gword(base);
        end else begin
            for (int i = 0; i < 4; i++) by[i] = gmem[base + 14'(i)];
            for (int i = 0; i < n; i++) by[addr[1:0] + i] = wd[8*i +: 8];
            exp_r_en[c]     = 1;
            exp_r_addr[c]   = addr[13:2];
            exp_busy[c+1]   = 1;
            exp_w_en[c+1]   = 1;
            exp_w_addr[c+1] = addr[13:2];
            exp_w_data[c+1] = {by[3], by[2], by[1], by[0]};
            pend_valid = 1;
            pend_addr  = addr[13:0];
            pend_n     = n;
            pend_data  = wd;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int waited;
        waited     = 0;
        req_valid  = 1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        else model_accept(we, f3, addr, wd, int'(cyc));
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model tables.
    logic [31:0] model_rdata = 0;
    logic [31:0] last_rsp    = 0;
    logic [31:0] last_wdata  = 0;
    int          err_cnt     = 0;
    bit          prev_rst    = 0;

    initial begin
        int k;
        @(posedge clk);
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            k = int'(cyc);
            if (!rst) begin
                chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
                chk("rst_w_en",      {31'd0, ram_w_en},  32'd0);
                chk("rst_r_en",      {31'd0, ram_r_en},  32'd0);
                chk("rst_w_addr",    32'(ram_w_addr),    32'd0);
                chk("rst_r_addr",    32'(ram_r_addr),    32'd0);
                chk("rst_w_data",    ram_w_data,         32'd0);
                model_rdata = 0;
                if (!prev_rst) begin
                    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                    chk("rst_err",       {31'd0, err_o},     32'd0);
                    chk("rst_rdata",     rsp_rdata,          32'd0);
                end
            end else begin
                chk("req_ready", {31'd0, req_ready}, {31'd0, !exp_busy[k]});
                chk("w_en",      {31'd0, ram_w_en},  {31'd0, exp_w_en[k]});
                if (exp_w_en[k]) begin
                    chk("w_addr", 32'(ram_w_addr), 32'(exp_w_addr[k]));
                    chk("w_data", ram_w_data, exp_w_data[k]);
                end
                chk("r_en", {31'd0, ram_r_en}, {31'd0, exp_r_en[k]});
                if (exp_r_en[k]) chk("r_addr", 32'(ram_r_addr), 32'(exp_r_addr[k]));
                if (exp_rsp[k]) model_rdata = exp_rdata[k];
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp[k]});
                chk("rsp_rdata", rsp_rdata, model_rdata);
                chk("err_o",     {31'd0, err_o},     {31'd0, exp_err[k]});
                if (rsp_valid) last_rsp = rsp_rdata;
                if (ram_w_en)  last_wdata = ram_w_data;
                if (err_o)     err_cnt++;
            end
            prev_rst = rst;
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 0;
        for (int i = 0; i < NB; i++) gmem[i] = 0;
        ram_r_data = 0;
        pend_valid = 0;
        rst = 0;
        req_valid = 0;
        req_we = 0;
        req_funct3 = 0;
        req_addr = 0;
        req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        idle(1);

        // SW then LW round trip
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        do_req(0, 3'b010, 32'h10, 32'h0);
        idle(3);
        chk("lw_deadbeef", last_rsp, 32'hDEADBEEF);

        // SB read-modify-write then LW
        do_req(1, 3'b000, 32'h11, 32'h55);
        do_req(0, 3'b010, 32'h10, 32'h0);
        chk("sb_merge_wdata", last_wdata, 32'hDEAD55EF);
        idle(3);
        chk("lw_after_sb", last_rsp, 32'hDEAD55EF);

        // Sub-word loads with extension
        do_req(1, 3'b010, 32'h10, 32'h80FF1234);
        idle(1);
        chk("model_lh", load_val(3'b001, 32'h12), 32'hFFFF80FF);
        chk("model_lb", load_val(3'b000, 32'h13), 32'hFFFFFF80);
        do_req(0, 3'b001, 32'h12, 32'h0);
        idle(3);
        chk("lh_12", last_rsp, 32'hFFFF80FF);
        do_req(0, 3'b101, 32'h12, 32'h0);
        idle(3);
        chk("lhu_12", last_rsp, 32'h000080FF);
        do_req(0, 3'b000, 32'h13, 32'h0);
        idle(3);
        chk("lb_13", last_rsp, 32'hFFFFFF80);
        do_req(0, 3'b100, 32'h13, 32'h0);
        idle(3);
        chk("lbu_13", last_rsp, 32'h00000080);
        do_req(0, 3'b000, 32'h10, 32'h0);
        do_req(0, 3'b101, 32'h10, 32'h0);
        idle(3);
        chk("lhu_10", last_rsp, 32'h00001234);
        do_req(0, 3'b010, 32'h10010, 32'h0);
        idle(3);
        chk("lw_upper_ignored", last_rsp, 32'h80FF1234);

        // Error cases
        do_req(0, 3'b010, 32'h11, 32'h0);
        do_req(1, 3'b001, 32'h13, 32'h1234);
        do_req(0, 3'b011, 32'h0, 32'h0);
        do_req(1, 3'b100, 32'h4, 32'h77);
        do_req(0, 3'b001, 32'h11, 32'h0);
        idle(2);
        chk("err_count", 32'(err_cnt), 32'd5);

        // Reset during RMW_MERGE drops the store
        do_req(1, 3'b010, 32'h20, 32'h11223344);
        do_req(1, 3'b001, 32'h20, 32'h0000BEEF);
        rst = 0;
        pend_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_w_en[cyc+i] = 0;
            exp_r_en[cyc+i] = 0;
            exp_busy[cyc+i] = 0;
            exp_rsp[cyc+i]  = 0;
            exp_err[cyc+i]  = 0;
        end
        idle(2);
        rst = 1;
        idle(1);
        do_req(0, 3'b010, 32'h20, 32'h0);
        idle(3);
        chk("lw_after_reset", last_rsp, 32'h11223344);

        // SW immediately followed by SB to the same word
        do_req(1, 3'b010, 32'h30, 32'hCAFEF00D);
        do_req(1, 3'b000, 32'h31, 32'hAA);
        idle(1);
        chk("sw_sb_merge", last_wdata, 32'hCAFEAA0D);
        do_req(1, 3'b001, 32'h32, 32'h1357);
        do_req(0, 3'b010, 32'h30, 32'h0);
        idle(3);
        chk("lw_30", last_rsp, 32'h1357AA0D);

        // Back-to-back SWs then loads
        do_req(1, 3'b010, 32'h40, 32'h01020304);
        do_req(1, 3'b010, 32'h44, 32'hF0E0D0C0);
        do_req(0, 3'b000, 32'h47, 32'h0);
        idle(3);
        chk("lb_47", last_rsp, 32'hFFFFFFF0);
        do_req(0, 3'b001, 32'h40, 32'h0);
        idle(3);
        chk("lh_40", last_rsp, 32'h00000304);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
- Load/store adapter between the MEM pipeline stage and the word-wide dual-port data RAM. The RAM has a separate write port, a 1-cycle registered read and no byte enables.
- Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM port activity.
- Performs read-modify-write for sub-word stores, and extracts plus sign/zero-extends load data.
- Stalls the pipeline through req_ready while a RAM read is outstanding.

Parameters:
- AW, 12, RAM word-address width; RAM word index = req_addr[AW+1:2], upper address bits ignored.
- DW, 32, data width; fixed at 32, no other value supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  access request from MEM stage
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- rsp_valid  out  1  load data valid, 1-cycle pulse
- rsp_rdata  out  32  extended load data
- err_o  out  1  misaligned or illegal-funct3 pulse
- ram_w_en  out  1  RAM write enable
- ram_w_addr  out  AW  RAM write word address
- ram_w_data  out  32  RAM write data
- ram_r_en  out  1  RAM read enable
- ram_r_addr  out  AW  RAM read word address
- ram_r_data  in  32  RAM read data, valid 1 cycle after ram_r_en

Behaviour:
- Byte order is little-endian: byte k = bits [8k+7:8k]. Offset is req_addr[1:0].
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE.
- req_ready is 1 only in IDLE and not in reset.
- Accept in IDLE, legal load:
  - ram_r_en = 1 and ram_r_addr = word index, combinationally in the accept cycle.
  - Latch funct3 and offset; go to LOAD_WAIT.
- LOAD_WAIT:
  - Sample ram_r_data and extract by latched offset/funct3.
  - B: sign-extend byte[offset]. BU: zero-extend byte[offset].
  - H: sign-extend half[offset[1]]. HU: zero-extend half[offset[1]]. W: full word.
  - Register the result. rsp_valid = 1 and rsp_rdata are valid in the following cycle, i.e. 2 cycles after accept. Return to IDLE.
  - rsp_rdata holds its value until the next load response.
- Accept in IDLE, aligned SW:
  - ram_w_en = 1, ram_w_addr = word index, ram_w_data = req_wdata, combinationally in the accept cycle.
  - Stay in IDLE; 0-stall, back-to-back SW allowed every cycle.
- Accept in IDLE, legal SB/SH:
  - Issue ram_r_en at the word index in the accept cycle.
  - Latch wdata, offset and size; go to RMW_MERGE.
- RMW_MERGE:
  - ram_w_en = 1 at the latched word index.
  - ram_w_data = ram_r_data with the target byte (SB) or half (SH) replaced by req_wdata[7:0] / [15:0]. All other bytes unchanged.
  - Return to IDLE. Store occupancy is 2 cycles.
- Error cases (no RAM access, no rsp_valid, stay in IDLE):
  - Misaligned: H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0.
  - Illegal funct3: 011, 110, 111, or store with funct3[2] = 1.
  - Response: err_o = 1 for exactly one cycle, the cycle after accept.
- ram_w_en and ram_r_en are never both 1 for the same word address in the same cycle. The RAM's same-address read/write bypass is therefore never exercised.
- Reset (rst = 0, synchronous):
  - State becomes IDLE; rsp_valid = 0, rsp_rdata = 0, err_o = 0.
  - ram_w_en = ram_r_en = 0 in any cycle with rst = 0.
  - ram_w_addr, ram_r_addr and ram_w_data read 0 in reset.
  - A pending RMW or load is dropped: no write issued, no response produced after reset releases.
- req_valid while not ready is ignored. The requester must hold the request until accepted.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ram_w_en in the accept cycle at word 4; rsp_valid 2 cycles after the LW accept with rsp_rdata = 0xDEADBEEF.
- SB addr 0x11 data 0x55 onto word 0xDEADBEEF, then LW 0x10 -> req_ready = 0 for one cycle; write data 0xDEAD55EF; LW returns 0xDEAD55EF.
- LH 0x12 / LHU 0x12 / LB 0x13 / LBU 0x13 on word 0x80FF1234 -> 0xFFFF80FF / 0x000080FF / 0xFFFFFF80 / 0x00000080.
- LW 0x11, SH 0x13, funct3 011 -> err_o pulse each, no ram_r_en/ram_w_en, no rsp_valid.
- SH 0x20 accepted, rst = 0 during RMW_MERGE -> no ram_w_en; word 8 unchanged on a later LW; outputs 0 during reset.
- SW 0x30 followed immediately by SB 0x31 data 0xAA -> SB read sees the SW data; final word = SW data with byte 1 = 0xAA.
